// File: rtl/cj_pkg.sv
// Shared types, error codes and tohost encoding for the cj_cosim commit-stream checker.
package cj_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned CODE_W = 3;

    typedef logic [CODE_W-1:0] err_code_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } commit_t;

    localparam err_code_t CJ_ERR_PC        = 3'd2;
    localparam err_code_t CJ_ERR_INSN      = 3'd3;
    localparam err_code_t CJ_ERR_UNDERFLOW = 3'd4;
    localparam err_code_t CJ_ERR_OVERFLOW  = 3'd5;

    // riscv-tests style: bit0 = done, upper bits = exit code
    function automatic logic [XLEN-1:0] tohost_encode(input err_code_t code);
        return (XLEN'(code) << 1) | XLEN'(1);
    endfunction

endpackage

// File: rtl/cj_fifo.sv
// Synchronous FIFO of DUT commit records; the caller never pushes when full without popping,
// and never pops when empty.
module cj_fifo
    import cj_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  commit_t din,
    output commit_t head_c,
    output logic    full_c,
    output logic    empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    commit_t          mem_q [DEPTH];
    commit_t          mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);

endmodule

// File: rtl/cj_cosim.sv
// Commit-stream co-simulation checker and tohost source.
// Build option: CJ_COMMIT_CHECK_EN enables the commit FIFO, comparator and error codes.
module cj_cosim
    import cj_pkg::*;
#(
    parameter logic [63:0] TOHOST_ADDR = 64'h8000_1000,
    parameter int unsigned DEPTH       = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [63:0] st_addr,
    input  logic [63:0] st_data,
    input  logic [7:0]  st_mask,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic [31:0] commit_insn,
    input  logic        ref_valid,
    input  logic [63:0] ref_pc,
    input  logic [31:0] ref_insn,
    output logic [63:0] tohost,
    output logic [63:0] checked
);

    logic [XLEN-1:0] tohost_q, tohost_d;
    logic [XLEN-1:0] st_merge_c;
    logic            st_hit_c;
    logic            err_valid_c;
    err_code_t       err_code_c;

    assign st_hit_c = st_valid && (st_addr == TOHOST_ADDR);

    // Byte-enable merge of store data into the current tohost value
    always_comb begin
        st_merge_c = tohost_q;
        for (int b = 0; b < 8; b++) begin
            if (st_mask[b]) begin
                st_merge_c[b*8 +: 8] = st_data[b*8 +: 8];
            end
        end
    end

`ifdef CJ_COMMIT_CHECK_EN
    logic [XLEN-1:0] checked_q, checked_d;
    commit_t         commit_in_c;
    commit_t         fifo_head_c;
    commit_t         cmp_c;
    logic            fifo_full_c, fifo_empty_c;
    logic            bypass_c, pop_c, push_c, cmp_valid_c;
    logic            pc_err_c, insn_err_c, underflow_c, overflow_c, pass_c;

    assign commit_in_c = '{pc: commit_pc, insn: commit_insn};

    assign bypass_c    = fifo_empty_c && commit_valid && ref_valid;
    assign pop_c       = ref_valid && !fifo_empty_c;
    assign cmp_valid_c = bypass_c || pop_c;
    assign cmp_c       = bypass_c ? commit_in_c : fifo_head_c;

    assign pc_err_c    = cmp_valid_c && (cmp_c.pc != ref_pc);
    assign insn_err_c  = cmp_valid_c && (cmp_c.insn != ref_insn);
    assign pass_c      = cmp_valid_c && !pc_err_c && !insn_err_c;
    assign underflow_c = ref_valid && fifo_empty_c && !commit_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign overflow_c  = commit_valid && !bypass_c && fifo_full_c && !pop_c;
    assign push_c      = commit_valid && !bypass_c && !overflow_c;

    cj_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .push    (push_c),
        .pop     (pop_c),
        .din     (commit_in_c),
        .head_c  (fifo_head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    // Highest-priority error for this cycle
    always_comb begin
        err_valid_c = 1'b0;
        err_code_c  = CJ_ERR_PC;
        if (pc_err_c) begin
            err_valid_c = 1'b1;
            err_code_c  = CJ_ERR_PC;
        end else if (insn_err_c) begin
            err_valid_c = 1'b1;
            err_code_c  = CJ_ERR_INSN;
        end else if (underflow_c) begin
            err_valid_c = 1'b1;
            err_code_c  = CJ_ERR_UNDERFLOW;
        end else if (overflow_c) begin
            err_valid_c = 1'b1;
            err_code_c  = CJ_ERR_OVERFLOW;
        end
    end

    always_comb begin
        checked_d = checked_q;
        if (pass_c) begin
            checked_d = checked_q + XLEN'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            checked_q <= '0;
        end else begin
            checked_q <= checked_d;
        end
    end

    assign checked = checked_q;
`else
    logic unused_c;

    assign unused_c    = ^{commit_valid, commit_pc, commit_insn,
                           ref_valid, ref_pc, ref_insn, 32'(DEPTH)};
    assign err_valid_c = 1'b0;
    assign err_code_c  = CJ_ERR_PC;
    assign checked     = '0;
`endif

    // Errors beat stores; once done is set the value is frozen until reset
    always_comb begin
        tohost_d = tohost_q;
        if (!tohost_q[0]) begin
            if (err_valid_c) begin
                tohost_d = tohost_encode(err_code_c);
            end else if (st_hit_c) begin
                tohost_d = st_merge_c;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tohost_q <= '0;
        end else begin
            tohost_q <= tohost_d;
        end
    end

    assign tohost = tohost_q;

endmodule

// File: tb/tb_cj_cosim.sv
// Self-checking bench for cj_cosim: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_cj_cosim;
    import cj_pkg::*;

    localparam logic [63:0] A     = 64'h8000_1000;
    localparam int unsigned DEPTH = 8;
`ifdef CJ_COMMIT_CHECK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        st_valid = 1'b0;
    logic [63:0] st_addr = '0;
    logic [63:0] st_data = '0;
    logic [7:0]  st_mask = '0;
    logic        commit_valid = 1'b0;
    logic [63:0] commit_pc = '0;
    logic [31:0] commit_insn = '0;
    logic        ref_valid = 1'b0;
    logic [63:0] ref_pc = '0;
    logic [31:0] ref_insn = '0;
    logic [63:0] tohost;
    logic [63:0] checked;

    int n_checks = 0;
    int n_fail   = 0;

    cj_cosim #(.TOHOST_ADDR(A), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_mask      (st_mask),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_insn  (commit_insn),
        .ref_valid    (ref_valid),
        .ref_pc       (ref_pc),
        .ref_insn     (ref_insn),
        .tohost       (tohost),
        .checked      (checked)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        logic        sv;
        logic [63:0] sa;
        logic [63:0] sd;
        logic [7:0]  sm;
        logic        cv;
        logic [63:0] cpc;
        logic [31:0] ci;
        logic        rv;
        logic [63:0] rpc;
        logic [31:0] ri;
        logic [63:0] exp_th;
        logic [63:0] exp_ck;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    commit_t     mq[$];
    logic [63:0] tohost_m;
    logic [63:0] checked_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
        commit_valid = 1'b0; commit_pc = '0; commit_insn = '0;
        ref_valid = 1'b0; ref_pc = '0; ref_insn = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        mq.delete();
        tohost_m  = '0;
        checked_m = '0;
    endtask

    task automatic drive(input vec_t v);
        @(negedge clock);
        st_valid = v.sv; st_addr = v.sa; st_data = v.sd; st_mask = v.sm;
        commit_valid = v.cv; commit_pc = v.cpc; commit_insn = v.ci;
        ref_valid = v.rv; ref_pc = v.rpc; ref_insn = v.ri;
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t cmt(input logic [63:0] pc, input logic [31:0] insn);
        vec_t v = '{0, 0, 0, 0, 0, 1, pc, insn, 0, 0, 0, 0, 0};
        return v;
    endfunction

    // One clock of the model, from the current inputs and the rules of the checker
    task automatic model_step();
        int        sz = mq.size();
        bit        bypass = 0, popped = 0, err = 0, pass = 0;
        int        code = 0;
        commit_t   exp_c;
        if (EN) begin
            bypass = (sz == 0) && commit_valid && ref_valid;
            popped = ref_valid && (sz > 0);
            if (bypass || popped) begin
                if (bypass) exp_c = '{pc: commit_pc, insn: commit_insn};
                else        exp_c = mq.pop_front();
                if (exp_c.pc != ref_pc)          begin err = 1; code = 2; end
                else if (exp_c.insn != ref_insn) begin err = 1; code = 3; end
                else pass = 1;
            end else if (ref_valid) begin
                err = 1; code = 4;
            end
            if (commit_valid && !bypass) begin
                if (sz == DEPTH && !popped) begin
                    if (!err) begin err = 1; code = 5; end
                end else begin
                    mq.push_back('{pc: commit_pc, insn: commit_insn});
                end
            end
        end
        if (!tohost_m[0]) begin
            if (err) tohost_m = 64'(code) * 2 + 1;
            else if (st_valid && st_addr == A) begin
                for (int b = 0; b < 8; b++)
                    if (st_mask[b]) tohost_m[b*8 +: 8] = st_data[b*8 +: 8];
            end
        end
        if (pass) checked_m = checked_m + 1;
    endtask

    initial begin
        vec_t v;
        commit_t base;
        int r;

        // Directed table: {rst, store, commit, ref, expected tohost, expected checked}
        vecs.push_back('{0, 1, A,     64'h1,    8'hFF, 0, 0, 0, 0, 0, 0, 64'h1, 0});
        vecs.push_back('{0, 1, A,     64'h3,    8'hFF, 0, 0, 0, 0, 0, 0, 64'h1, 0});
        vecs.push_back('{1, 1, A + 8, 64'h5,    8'hFF, 0, 0, 0, 0, 0, 0, 64'h0, 0});
        vecs.push_back('{0, 1, A,     64'h0A00, 8'h02, 0, 0, 0, 0, 0, 0, 64'h0A00, 0});
        vecs.push_back('{0, 1, A,     '1,       8'h00, 0, 0, 0, 0, 0, 0, 64'h0A00, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 1, 64'h8000_0000, 32'h0000_0013, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 1, 64'h8000_0004, 32'h0010_0093, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 1, 64'h8000_0008, 32'h0020_0113, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 32'h0000_0013, 0, EN ? 64'd1 : 64'd0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0004, 32'h0010_0093, 0, EN ? 64'd2 : 64'd0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0008, 32'h0020_0113, 0, EN ? 64'd3 : 64'd0});
        vecs.push_back('{1, 0, 0, 0, 0, 1, 64'h8000_0000, 32'h13, 1, 64'h8000_0004, 32'h13, EN ? 64'd5 : 64'd0, 0});
        vecs.push_back('{0, 1, A, 64'h1, 8'hFF, 0, 0, 0, 0, 0, 0, EN ? 64'd5 : 64'd1, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 32'h13, EN ? 64'd9 : 64'd0, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 1, 64'h8000_0010, 32'h33, 1, 64'h8000_0010, 32'h33, 0, EN ? 64'd1 : 64'd0});
        vecs.push_back('{0, 0, 0, 0, 0, 1, 64'h8000_0014, 32'h33, 1, 64'h8000_0014, 32'h37, EN ? 64'd7 : 64'd0, EN ? 64'd1 : 64'd0});
        vecs.push_back('{1, 1, A, 64'h2, 8'hFF, 0, 0, 0, 1, 64'h8000_0000, 32'h13, EN ? 64'd9 : 64'd2, 0});

        // Reset state, including while reset is held
        @(negedge clock);
        check("reset_hold_tohost", tohost, 64'h0);
        do_reset();
        #1;
        check("reset_tohost", tohost, 64'h0);
        check("reset_checked", checked, 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i]);
            check($sformatf("vec%0d_tohost", i), tohost, vecs[i].exp_th);
            check($sformatf("vec%0d_checked", i), checked, vecs[i].exp_ck);
        end

        // Overflow: DEPTH pushes fill the FIFO, one more is dropped
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(cmt(64'h8000_0000 + 64'(i * 4), 32'(i)));
        check("fill_tohost", tohost, 64'h0);
        drive(cmt(64'h8000_1000, 32'h99));
        check("overflow_tohost", tohost, EN ? 64'd11 : 64'd0);

        // Full FIFO with a simultaneous pop is not an overflow; refilling then overflows
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(cmt(64'h8000_0000 + 64'(i * 4), 32'(i)));
        v = cmt(64'h8000_0100, 32'h77);
        v.rv = 1; v.rpc = 64'h8000_0000; v.ri = 32'h0;
        drive(v);
        check("full_pop_tohost", tohost, 64'h0);
        check("full_pop_checked", checked, EN ? 64'd1 : 64'd0);
        drive(cmt(64'h8000_0104, 32'h78));
        check("refill_overflow_tohost", tohost, EN ? 64'd11 : 64'd0);

        // Asynchronous reset mid-round clears tohost without a clock edge
        do_reset();
        v = '{0, 1, A, 64'h1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(v);
        check("pre_async_tohost", tohost, 64'h1);
        @(negedge clock);
        clear_inputs();
        #2 reset = 1'b0;
        #1;
        check("async_reset_tohost", tohost, 64'h0);
        @(negedge clock);
        reset = 1'b1;

        // Randomized traffic against the reference model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(199) == 0) do_reset();
            @(negedge clock);
            commit_valid = ($urandom_range(99) < 50);
            commit_pc    = 64'h8000_0000 + 64'($urandom_range(255)) * 4;
            commit_insn  = $urandom;
            ref_valid    = (mq.size() > 0 || commit_valid) ? ($urandom_range(99) < 50)
                                                           : ($urandom_range(99) < 3);
            if (mq.size() > 0) base = mq[0];
            else               base = '{pc: commit_pc, insn: commit_insn};
            ref_pc   = base.pc;
            ref_insn = base.insn;
            r = $urandom_range(99);
            if (r < 2)      ref_pc   = ref_pc ^ 64'h4;
            else if (r < 4) ref_insn = ref_insn ^ (32'h1 << $urandom_range(31));
            st_valid = ($urandom_range(99) < 8);
            r = $urandom_range(3);
            st_addr  = (r == 0) ? A + 8 : A;
            st_data  = {$urandom, $urandom};
            if ($urandom_range(9) != 0) st_data[0] = 1'b0;
            st_mask  = 8'($urandom);
            @(posedge clock);
            model_step();
            #1;
            check("rand_tohost", tohost, tohost_m);
            check("rand_checked", checked, checked_m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
